dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (datamem) between two requesters: port 0 (lw/sw

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//  - state_t : arbiter FSM encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//  - ADDR_W_DEF / DATA_W_DEF : default address and data widths (match datamem)
//  - RW_READ / RW_WRITE : datamem readwrite encoding
package dmem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick (purely combinational).
// Ports:
//  req[1:0] in  : request from port 1 (bit 1) and port 0 (bit 0)
//  rr_last  in  : port served most recently
//  win      out : index of the winning port (meaningful only with valid)
//  valid    out : at least one request present
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       win,
  output logic       valid
);

  always_comb begin
    valid = |req;
    win   = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      // Tie: the port that was not served last goes next.
      2'b11:   win = ~rr_last;
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port datamem between port 0 (load/store path) and port 1
// (loader/debug). Round-robin, one access in flight.
//
// Handshake: a requester raises rN_req with rN_we/rN_addr/rN_wdata stable and
// holds them until rN_done. rN_gnt pulses one cycle when the access is taken,
// rN_done pulses one cycle when it completes (rN_rdata valid with it on reads).
// A request still high in the cycle that carries rN_done is sampled as a new
// access; a request dropped before its grant leaves no trace.
//
// Ports:
//  clk, rst                 clock, asynchronous active-low reset
//  rN_req/we/addr/wdata     requester inputs (N = 0, 1)
//  rN_gnt, rN_done, rN_rdata requester outputs
//  mem_en/rw/addr/wdata     to datamem (enable, readwrite, Ina, Inb)
//  mem_rdata                from datamem dataOut
//  dbg_state                current FSM state, for observation only
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r1_req,
  input  logic              r0_we,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_done,
  output logic              r1_done,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            dbg_state
);

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       rr_last;
  logic       cur_port;
  logic       pick;
  logic       pick_valid;

  rr_arb2 u_rr_arb2 (
    .req     ({r1_req, r0_req}),
    .rr_last (rr_last),
    .win     (pick),
    .valid   (pick_valid)
  );

  assign dbg_state = state;

  // All outputs are registered, so each one appears the cycle after the state
  // that decides it: gnt is visible while in ISSUE, mem_en in the cycle after
  // ISSUE, done in the cycle after RESP. The read data is captured on leaving
  // RESP, which is exactly RD_LAT cycles after the mem_en cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      rr_last   <= 1'b1;
      cur_port  <= 1'b0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_rw    <= RW_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      r0_gnt  <= 1'b0;
      r1_gnt  <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      mem_en  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            cur_port  <= pick;
            // The mem_* registers double as the request latch; they hold
            // their value until the next grant.
            mem_rw    <= pick ? r1_we    : r0_we;
            mem_addr  <= pick ? r1_addr  : r0_addr;
            mem_wdata <= pick ? r1_wdata : r0_wdata;
            r0_gnt    <= ~pick;
            r1_gnt    <= pick;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en <= 1'b1;
          if (mem_rw == RW_WRITE) begin
            state <= ST_RESP;
          end else begin
            cnt   <= CNT_INIT;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (mem_rw == RW_READ) begin
            if (cur_port) begin
              r1_rdata <= mem_rdata;
            end else begin
              r0_rdata <= mem_rdata;
            end
          end
          r0_done <= ~cur_port;
          r1_done <= cur_port;
          rr_last <= cur_port;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance "a" with RD_LAT=1 carries most scenarios,
// instance "b" with RD_LAT=3 checks the longer read latency. Each instance has
// a small behavioural datamem whose read data is only valid in the one cycle
// it is due, so early or late capture is visible.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [DW-1:0] BAD = 32'hBAD0_BAD0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance a (RD_LAT=1) ----------------
  logic          r0_req = 0, r1_req = 0, r0_we = 0, r1_we = 0;
  logic [AW-1:0] r0_addr = 0, r1_addr = 0;
  logic [DW-1:0] r0_wdata = 0, r1_wdata = 0;
  logic          r0_gnt, r1_gnt, r0_done, r1_done;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_en, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  state_t        dbg_state;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- instance b (RD_LAT=3) ----------------
  logic          b_r0_req = 0, b_r0_we = 0;
  logic [AW-1:0] b_r0_addr = 0;
  logic [DW-1:0] b_r0_wdata = 0;
  logic          b_r0_gnt, b_r1_gnt, b_r0_done, b_r1_done;
  logic [DW-1:0] b_r0_rdata, b_r1_rdata;
  logic          b_mem_en, b_mem_rw;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;
  state_t        b_dbg_state;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .r0_req(b_r0_req), .r1_req(1'b0), .r0_we(b_r0_we), .r1_we(1'b0),
    .r0_addr(b_r0_addr), .r1_addr('0), .r0_wdata(b_r0_wdata), .r1_wdata('0),
    .r0_gnt(b_r0_gnt), .r1_gnt(b_r1_gnt), .r0_done(b_r0_done), .r1_done(b_r1_done),
    .r0_rdata(b_r0_rdata), .r1_rdata(b_r1_rdata),
    .mem_en(b_mem_en), .mem_rw(b_mem_rw), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .dbg_state(b_dbg_state)
  );

  // ---------------- behavioural datamem models ----------------
  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];
  logic          a_v;
  logic [DW-1:0] a_d;
  logic [2:0]    b_v;
  logic [DW-1:0] b_d0, b_d1, b_d2;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= 32'hA000_0000 + i;
        mem_b[i] <= 32'hB000_0000 + i;
      end
      a_v <= 1'b0;
      b_v <= 3'b000;
    end else begin
      if (mem_en && mem_rw) mem_a[mem_addr[3:0]] <= mem_wdata;
      a_v <= mem_en && !mem_rw;
      a_d <= mem_a[mem_addr[3:0]];
      if (b_mem_en && b_mem_rw) mem_b[b_mem_addr[3:0]] <= b_mem_wdata;
      b_v  <= {b_v[1:0], b_mem_en && !b_mem_rw};
      b_d0 <= mem_b[b_mem_addr[3:0]];
      b_d1 <= b_d0;
      b_d2 <= b_d1;
    end
  end

  assign mem_rdata   = a_v    ? a_d  : BAD;
  assign b_mem_rdata = b_v[2] ? b_d2 : BAD;

  // ---------------- event recorder ----------------
  logic gnt_log[$];
  logic [DW-1:0] exp_q[$];
  int both_gnt = 0, en_cnt = 0, en_cnt_b = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (r0_gnt) gnt_log.push_back(1'b0);
    if (r1_gnt) gnt_log.push_back(1'b1);
    if (r0_gnt && r1_gnt) both_gnt++;
    if (mem_en) en_cnt++;
    if (b_mem_en) en_cnt_b++;
    if (r0_done || r1_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int d0;
    repeat (2) step();
    total++;
    if ({r0_gnt, r1_gnt, r0_done, r1_done, mem_en, mem_rw, mem_addr, mem_wdata, r0_rdata, r1_rdata} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {r0_gnt, r1_gnt, r0_done, r1_done, mem_en, mem_rw, mem_addr, mem_wdata, r0_rdata, r1_rdata});
    end
    total++;
    if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    rst = 1'b1;
    step();
    // start a read, then reset while it is waiting on memory
    r0_req = 1; r0_we = 0; r0_addr = 3;
    step();
    total++;
    if (r0_gnt !== 1'b1) begin bad++; $display("FAIL mid_read_gnt: got %b want 1", r0_gnt); end
    step();
    total++;
    if (dbg_state !== ST_WAIT || mem_en !== 1'b1) begin
      bad++; $display("FAIL mid_read_wait: state %0d en %b want state %0d en 1", dbg_state, mem_en, ST_WAIT);
    end
    rst = 1'b0; r0_req = 0;
    #1;
    total++;
    if ({r0_gnt, r1_gnt, r0_done, r1_done, mem_en, mem_rw, mem_addr, mem_wdata, r0_rdata, r1_rdata, dbg_state} !== '0) begin
      bad++; $display("FAIL async_reset: got %h want 0", {r0_gnt, r1_gnt, r0_done, r1_done, mem_en, mem_rw, mem_addr, mem_wdata, r0_rdata, r1_rdata, dbg_state});
    end
    step();
    rst = 1'b1;
    d0 = done_cnt;
    repeat (6) step();
    total++;
    if (done_cnt != d0) begin bad++; $display("FAIL aborted_no_done: got %0d done pulses want 0", done_cnt - d0); end
    // first tie after reset goes to port 0
    r0_req = 1; r0_we = 0; r0_addr = 1;
    r1_req = 1; r1_we = 0; r1_addr = 2;
    step();
    total++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin bad++; $display("FAIL first_tie: got r0/r1 gnt %b want 10", {r0_gnt, r1_gnt}); end
    r1_req = 0;
    repeat (3) step();
    total++;
    if (r0_done !== 1'b1 || r0_rdata !== 32'hA000_0001) begin
      bad++; $display("FAIL first_tie_read: done %b data %h want 1 a0000001", r0_done, r0_rdata);
    end
    r0_req = 0;
    repeat (3) step();
  endtask

  task automatic test_write_read();
    int lat, e0;
    logic seen;
    e0 = en_cnt;
    r0_req = 1; r0_we = 1; r0_addr = 5; r0_wdata = 32'hDEADBEEF;
    step();
    total++;
    if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin bad++; $display("FAIL wr_gnt: got %b%b want 10", r0_gnt, r1_gnt); end
    step();
    total++;
    if ({mem_en, mem_rw, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'd5, 32'hDEADBEEF}) begin
      bad++; $display("FAIL wr_issue: got en %b rw %b addr %h data %h want 1 1 5 deadbeef", mem_en, mem_rw, mem_addr, mem_wdata);
    end
    step();
    total++;
    if (r0_done !== 1'b1) begin bad++; $display("FAIL wr_done: got %b want 1 at T+2", r0_done); end
    // re-raise at once as a read of the same word
    r0_we = 0;
    step();
    total++;
    if (r0_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt_spacing: got %b want 1 three cycles after previous gnt", r0_gnt); end
    lat = 0; seen = 0;
    while (!seen && lat < 12) begin
      step(); lat++;
      if (r0_done) seen = 1;
    end
    total++;
    if (!seen || lat != 3) begin bad++; $display("FAIL rd_latency1: got %0d (seen %b) want 3", lat, seen); end
    total++;
    if (r0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", r0_rdata); end
    r0_req = 0;
    repeat (3) step();
    total++;
    if (en_cnt - e0 != 2) begin bad++; $display("FAIL wr_rd_en_cycles: got %0d want 2", en_cnt - e0); end
  endtask

  task automatic test_contention();
    int g0, b0, ndone, n;
    logic [DW-1:0] got, want;
    logic [7:0] seq;
    g0 = gnt_log.size(); b0 = both_gnt;
    exp_q.delete();
    // last served was port 0, so port 1 starts and they alternate
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 32'hA000_0002 : 32'hA000_0001);
    r0_req = 1; r0_we = 0; r0_addr = 1;
    r1_req = 1; r1_we = 0; r1_addr = 2;
    ndone = 0; n = 0;
    while (ndone < 8 && n < 80) begin
      step(); n++;
      if (r0_done || r1_done) begin
        got  = r1_done ? r1_rdata : r0_rdata;
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL contention_data[%0d]: got %h want %h", ndone, got, want); end
        ndone++;
        if (ndone == 8) begin r0_req = 0; r1_req = 0; end
      end
    end
    total++;
    if (ndone != 8) begin bad++; $display("FAIL contention_timeout: got %0d done want 8", ndone); r0_req = 0; r1_req = 0; end
    repeat (4) step();
    total++;
    if (gnt_log.size() - g0 != 8) begin bad++; $display("FAIL contention_gnt_count: got %0d want 8", gnt_log.size() - g0); end
    seq = 'x;
    for (int i = 0; i < 8; i++) if (g0 + i < gnt_log.size()) seq[i] = gnt_log[g0 + i];
    total++;
    if (seq !== 8'h55) begin bad++; $display("FAIL contention_order: got %b want 01010101 (bit0 first)", seq); end
    total++;
    if (both_gnt != b0) begin bad++; $display("FAIL contention_both_gnt: got %0d want 0", both_gnt - b0); end
  endtask

  task automatic test_withdrawn();
    int g0, e0;
    g0 = gnt_log.size(); e0 = en_cnt;
    r0_req = 1; r0_we = 1; r0_addr = 7; r0_wdata = 32'h0000_0077;
    step();
    total++;
    if (r0_gnt !== 1'b1) begin bad++; $display("FAIL wd_r0_gnt: got %b want 1", r0_gnt); end
    r1_req = 1; r1_we = 0; r1_addr = 3;
    step();
    r1_req = 0;
    step();
    total++;
    if (r0_done !== 1'b1) begin bad++; $display("FAIL wd_r0_done: got %b want 1", r0_done); end
    r0_req = 0;
    repeat (4) step();
    total++;
    if (gnt_log.size() - g0 != 1) begin bad++; $display("FAIL wd_no_r1_gnt: got %0d grants want 1", gnt_log.size() - g0); end
    total++;
    if (en_cnt - e0 != 1) begin bad++; $display("FAIL wd_no_mem_access: got %0d en cycles want 1", en_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    // r0 alone holding req: regranted in the IDLE that carries its done
    r0_req = 1; r0_we = 0; r0_addr = 4;
    step();
    total++;
    if (r0_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt1: got %b want 1", r0_gnt); end
    repeat (3) step();
    total++;
    if (r0_done !== 1'b1 || r0_rdata !== 32'hA000_0004) begin bad++; $display("FAIL b2b_done1: done %b data %h want 1 a0000004", r0_done, r0_rdata); end
    step();
    total++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin bad++; $display("FAIL b2b_regrant: got %b want 10", {r0_gnt, r1_gnt}); end
    repeat (3) step();
    total++;
    if (r0_done !== 1'b1) begin bad++; $display("FAIL b2b_done2: got %b want 1", r0_done); end
    r0_req = 0;
    repeat (2) step();
    // r0 holding, r1 pending: r1 goes first
    r0_req = 1;
    step();
    total++;
    if (r0_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt3: got %b want 1", r0_gnt); end
    r1_req = 1; r1_we = 0; r1_addr = 6;
    repeat (3) step();
    total++;
    if (r0_done !== 1'b1) begin bad++; $display("FAIL b2b_done3: got %b want 1", r0_done); end
    step();
    total++;
    if ({r0_gnt, r1_gnt} !== 2'b01) begin bad++; $display("FAIL b2b_r1_first: got %b want 01", {r0_gnt, r1_gnt}); end
    repeat (3) step();
    total++;
    if (r1_done !== 1'b1 || r1_rdata !== 32'hA000_0006) begin bad++; $display("FAIL b2b_r1_done: done %b data %h want 1 a0000006", r1_done, r1_rdata); end
    r1_req = 0;
    step();
    total++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin bad++; $display("FAIL b2b_r0_after: got %b want 10", {r0_gnt, r1_gnt}); end
    repeat (3) step();
    total++;
    if (r0_done !== 1'b1) begin bad++; $display("FAIL b2b_done4: got %b want 1", r0_done); end
    r0_req = 0;
    repeat (2) step();
  endtask

  task automatic test_latency3();
    int lat, e0;
    logic seen;
    e0 = en_cnt_b;
    b_r0_req = 1; b_r0_we = 1; b_r0_addr = 9; b_r0_wdata = 32'h1234_5678;
    step();
    total++;
    if (b_r0_gnt !== 1'b1) begin bad++; $display("FAIL l3_wr_gnt: got %b want 1", b_r0_gnt); end
    repeat (2) step();
    total++;
    if (b_r0_done !== 1'b1) begin bad++; $display("FAIL l3_wr_done: got %b want 1 at T+2", b_r0_done); end
    b_r0_we = 0;
    step();
    total++;
    if (b_r0_gnt !== 1'b1) begin bad++; $display("FAIL l3_rd_gnt: got %b want 1", b_r0_gnt); end
    lat = 0; seen = 0;
    while (!seen && lat < 16) begin
      step(); lat++;
      if (b_r0_done) seen = 1;
    end
    total++;
    if (!seen || lat != 5) begin bad++; $display("FAIL l3_rd_latency: got %0d (seen %b) want 5", lat, seen); end
    total++;
    if (b_r0_rdata !== 32'h1234_5678) begin bad++; $display("FAIL l3_rd_data: got %h want 12345678", b_r0_rdata); end
    b_r0_req = 0;
    repeat (3) step();
    total++;
    if (en_cnt_b - e0 != 2) begin bad++; $display("FAIL l3_en_cycles: got %0d want 2", en_cnt_b - e0); end
    total++;
    if (b_dbg_state !== ST_IDLE || b_r1_gnt !== 1'b0 || b_r1_done !== 1'b0) begin
      bad++; $display("FAIL l3_idle: state %0d r1_gnt %b r1_done %b want 0 0 0", b_dbg_state, b_r1_gnt, b_r1_done);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_withdrawn();
    test_back_to_back();
    test_latency3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
